// File: rtl/mash111_dsm.sv
// MASH 1-1-1 delta-sigma modulator for fractional-N division: three cascaded
// first-order accumulators with carry noise-shaping and clamped divider ratio.
module mash111_dsm #(
    parameter int WIDTH     = 16,
    parameter bit DITHER_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frac_load,
    input  logic [WIDTH-1:0] frac_in,
    input  logic [7:0]       n_int,
    output logic [3:0]       div_offset,
    output logic [8:0]       div_ratio,
    output logic             valid
);

    logic [WIDTH-1:0] frac_reg;
    logic [WIDTH-1:0] acc1, acc2, acc3;
    logic [WIDTH:0]   s1, s2, s3;
    logic             c2_d1, c3_d1, c3_d2;
    logic [14:0]      lfsr;
    logic             d;
    logic [3:0]       y;
    logic [9:0]       ratio_sum;

    always_comb begin
        d = 1'b0;
        if (DITHER_EN)
            d = lfsr[0];
        s1 = {1'b0, acc1} + {1'b0, frac_reg} + {{WIDTH{1'b0}}, d};
        s2 = {1'b0, acc2} + {1'b0, s1[WIDTH-1:0]};
        s3 = {1'b0, acc3} + {1'b0, s2[WIDTH-1:0]};
        // Modulo-16 arithmetic yields the correct two's complement result in -3..+4
        y = {3'b000, s1[WIDTH]}
          + {3'b000, s2[WIDTH]} - {3'b000, c2_d1}
          + {3'b000, s3[WIDTH]} - {2'b00, c3_d1, 1'b0} + {3'b000, c3_d2};
        ratio_sum = {2'b00, n_int} + {{6{div_offset[3]}}, div_offset};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_reg   <= '0;
            acc1       <= '0;
            acc2       <= '0;
            acc3       <= '0;
            c2_d1      <= 1'b0;
            c3_d1      <= 1'b0;
            c3_d2      <= 1'b0;
            lfsr       <= 15'h0001;
            div_offset <= '0;
            div_ratio  <= '0;
            valid      <= 1'b0;
        end else begin
            if (frac_load)
                frac_reg <= frac_in;
            // Ratio follows n_int every cycle; negative sums clamp to zero
            div_ratio <= ratio_sum[9] ? '0 : ratio_sum[8:0];
            if (en) begin
                acc1       <= s1[WIDTH-1:0];
                acc2       <= s2[WIDTH-1:0];
                acc3       <= s3[WIDTH-1:0];
                c2_d1      <= s2[WIDTH];
                c3_d1      <= s3[WIDTH];
                c3_d2      <= c3_d1;
                div_offset <= y;
                valid      <= 1'b1;
                if (DITHER_EN)
                    lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            end
        end
    end

endmodule

// File: tb/tb_mash111_dsm.sv
// Scoreboard bench for mash111_dsm: plain and dithered instances driven in
// parallel and checked against an arithmetic model of the MASH equations.
module tb_mash111_dsm;

    localparam int W = 16;
    localparam int M = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        frac_load = 1'b0;
    logic [15:0] frac_in = '0;
    logic [7:0]  n_int = '0;
    logic [3:0]  off0, off1;
    logic [8:0]  rat0, rat1;
    logic        v0, v1;

    int checks = 0;
    int failures = 0;

    mash111_dsm #(.WIDTH(W), .DITHER_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .frac_load(frac_load), .frac_in(frac_in),
        .n_int(n_int), .div_offset(off0), .div_ratio(rat0), .valid(v0)
    );

    mash111_dsm #(.WIDTH(W), .DITHER_EN(1'b1)) dut_d (
        .clk(clk), .rst(rst), .en(en), .frac_load(frac_load), .frac_in(frac_in),
        .n_int(n_int), .div_offset(off1), .div_ratio(rat1), .valid(v1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc1, acc2, acc3, frac;
        int c2p, c3p, c3pp;
        int lfsr, off, ratio, valid;
    } model_t;

    typedef struct {
        int off0, rat0, val0, off1, rat1, val1;
    } exp_t;

    model_t m0, m1;
    exp_t   q[$];

    function automatic model_t model_reset();
        model_t m;
        m = '{default: 0};
        m.lfsr = 1;
        return m;
    endfunction

    // One clock edge of the modulator described with integer arithmetic
    function automatic model_t model_step(model_t m, bit dith, bit e, bit ld, int k, int n);
        int s1, s2, s3, c1, c2, c3, d, r;
        r = n + m.off;
        m.ratio = (r < 0) ? 0 : r;
        if (e) begin
            d = dith ? (m.lfsr % 2) : 0;
            s1 = m.acc1 + m.frac + d;
            c1 = s1 / M;  m.acc1 = s1 % M;
            s2 = m.acc2 + m.acc1;
            c2 = s2 / M;  m.acc2 = s2 % M;
            s3 = m.acc3 + m.acc2;
            c3 = s3 / M;  m.acc3 = s3 % M;
            m.off  = c1 + (c2 - m.c2p) + (c3 - 2 * m.c3p + m.c3pp);
            m.c3pp = m.c3p;
            m.c3p  = c3;
            m.c2p  = c2;
            m.valid = 1;
            if (dith)
                m.lfsr = ((m.lfsr * 2) % 32768) + (((m.lfsr / 16384) + (m.lfsr / 8192)) % 2);
        end
        if (ld)
            m.frac = k;
        return m;
    endfunction

    function automatic int sx(logic [3:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(bit e, bit ld, int k, int n);
        en = e;
        frac_load = ld;
        frac_in = k[15:0];
        n_int = n[7:0];
        @(posedge clk);
        #1;
        m0 = model_step(m0, 1'b0, e, ld, k, n);
        m1 = model_step(m1, 1'b1, e, ld, k, n);
        q.push_back('{m0.off, m0.ratio, m0.valid, m1.off, m1.ratio, m1.valid});
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_off0", sx(off0), 0);
        chk("rst_rat0", int'(rat0), 0);
        chk("rst_val0", int'(v0), 0);
        chk("rst_off1", sx(off1), 0);
        chk("rst_rat1", int'(rat1), 0);
        chk("rst_val1", int'(v1), 0);
        #1 rst = 1'b0;
        q.delete();
        m0 = model_reset();
        m1 = model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("off0", sx(off0), e.off0);
            chk("rat0", int'(rat0), e.rat0);
            chk("val0", int'(v0), e.val0);
            chk("off1", sx(off1), e.off1);
            chk("rat1", int'(rat1), e.rat1);
            chk("val1", int'(v1), e.val1);
            chk("range0", int'(sx(off0) >= -3 && sx(off0) <= 4), 1);
            chk("range1", int'(sx(off1) >= -3 && sx(off1) <= 4), 1);
        end
    end

    initial begin
        int pat4[4];
        int pat9[9];
        int sum;
        int nz;
        int k;
        int n;
        pat4 = '{0, 2, -1, 1};
        pat9 = '{0, 0, 2, -1, 1, 0, 2, -1, 1};
        m0 = model_reset();
        m1 = model_reset();

        #3;
        chk("init_off0", sx(off0), 0);
        chk("init_rat0", int'(rat0), 0);
        chk("init_val0", int'(v0), 0);
        chk("init_off1", sx(off1), 0);
        chk("init_val1", int'(v1), 0);
        #1 rst = 1'b0;

        // K = 1/2 preloaded: fixed period-4 pattern
        step(1'b0, 1'b1, 32768, 10);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32768, 10);
            #2 chk("pat_half", sx(off0), pat4[i % 4]);
        end

        // Freeze for 5 cycles then resume
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 0, 20 + i);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 0, 30);

        // Asynchronous reset mid-run, then load coincident with the first edge
        reset_pulse();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i == 0), 32768, 100);
            #2 chk("pat_restart", sx(off0), pat9[i]);
        end

        // K = 1/4 over 1024 cycles from reset: exact mean
        reset_pulse();
        step(1'b0, 1'b1, 16384, 100);
        sum = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 1'b0, 0, 100);
            #2 sum += sx(off0);
        end
        chk("sum_quarter", sum, 256);

        // K = 0: plain stays at zero, dithered must move
        reset_pulse();
        nz = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 0, 50);
            #2 if (sx(off1) != 0) nz++;
        end
        chk("dither_active", int'(nz > 0), 1);

        // Randomised enable, loads, K and n_int, biased to ratio clamp/top edges
        for (int i = 0; i < 2000; i++) begin
            k = int'($urandom_range(0, 65535));
            case ($urandom_range(0, 2))
                0:       n = int'($urandom_range(0, 5));
                1:       n = int'($urandom_range(250, 255));
                default: n = int'($urandom_range(0, 255));
            endcase
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0), k, n);
            if (i == 1000)
                reset_pulse();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
